// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types used by the writeback stage.
// Holds the result-select encoding, load funct3 codes and the MEM/WB bundle.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [1:0]  src;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } mem_wb_t;

endpackage

// File: rtl/iwriteback_load_ext.sv
// Load data extraction and sign/zero extension for RV32I loads.
// Halfword selection ignores addr[0]; misalignment is not trapped here.
module load_ext
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  assign half_sel = addr_i[1] ? word_i[31:16]
                              : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU: data_o = {24'h0, byte_sel};
      F3_LHU: data_o = {16'h0, half_sel};
      F3_LW:  data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/iwriteback.sv
// RV32I writeback stage: MEM/WB register, load extension, result mux
// and retired-instruction counter feeding the regfile write port.
module iwriteback
  import riscv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RETCNT_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallW,
  input  logic                FlushW,
  input  logic                ValidM,
  input  logic                RegWriteM,
  input  logic [1:0]          ResultSrcM,
  input  logic [2:0]          Funct3M,
  input  logic [DATA_W-1:0]   ALUResultM,
  input  logic [DATA_W-1:0]   ReadDataM,
  input  logic [4:0]          RdM,
  input  logic [DATA_W-1:0]   PCPlus4M,
  output logic                RegWriteW,
  output logic [4:0]          RdW,
  output logic [DATA_W-1:0]   ResultW,
  output logic                ValidW,
  output logic [RETCNT_W-1:0] InstRetW
);

  mem_wb_t             wb_q;
  mem_wb_t             wb_d;
  logic [RETCNT_W-1:0] ret_q;
  logic [RETCNT_W-1:0] ret_d;
  logic [31:0]         ld_data;

  always_comb begin
    wb_d          = '0;
    wb_d.valid    = ValidM;
    wb_d.regwrite = RegWriteM;
    wb_d.src      = ResultSrcM;
    wb_d.funct3   = Funct3M;
    wb_d.alu      = ALUResultM;
    wb_d.rdata    = ReadDataM;
    wb_d.rd       = RdM;
    wb_d.pc4      = PCPlus4M;
  end

  // Flush forces every field to zero so W never shows stale data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (FlushW) begin
      wb_q <= '0;
    end else if (!StallW) begin
      wb_q <= wb_d;
    end
  end

  always_comb begin
    ret_d = ret_q;
    if (wb_q.valid && !StallW) begin
      ret_d = ret_q + RETCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  load_ext u_load_ext (
    .funct3_i (wb_q.funct3),
    .addr_i   (wb_q.alu[1:0]),
    .word_i   (wb_q.rdata),
    .data_o   (ld_data)
  );

  always_comb begin
    RegWriteW = wb_q.regwrite & wb_q.valid
              & (wb_q.rd != 5'd0);
    RdW       = wb_q.rd;
    ValidW    = wb_q.valid;
    InstRetW  = ret_q;
    case (wb_q.src)
      RES_ALU: ResultW = wb_q.alu;
      RES_MEM: ResultW = ld_data;
      RES_PC4: ResultW = wb_q.pc4;
      default: ResultW = wb_q.alu;
    endcase
  end

endmodule

// File: tb/tb_iwriteback.sv
// Directed bench for the writeback stage, including a narrow-counter
// instance to reach the retire-counter wrap point quickly.
module tb_iwriteback;

  logic        clk;
  logic        reset;
  logic        StallW;
  logic        FlushW;
  logic        ValidM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        ValidW;
  logic [63:0] InstRetW;

  logic        s_RegWriteW;
  logic [4:0]  s_RdW;
  logic [31:0] s_ResultW;
  logic        s_ValidW;
  logic [3:0]  s_InstRetW;

  int checks;
  int failures;

  logic        mv;
  logic [63:0] ret;

  iwriteback #(.DATA_W(32), .RETCNT_W(64)) dut (
    .clk(clk), .reset(reset),
    .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .ValidW(ValidW),
    .InstRetW(InstRetW)
  );

  iwriteback #(.DATA_W(32), .RETCNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteW(s_RegWriteW), .RdW(s_RdW),
    .ResultW(s_ResultW), .ValidW(s_ValidW),
    .InstRetW(s_InstRetW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    if (!reset) begin
      mv  = 1'b0;
      ret = '0;
    end else begin
      if (mv && !StallW) ret = ret + 64'd1;
      if (FlushW) mv = 1'b0;
      else if (!StallW) mv = ValidM;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic rw,
                       input logic [1:0] src,
                       input logic [2:0] f3,
                       input logic [31:0] alu,
                       input logic [31:0] rdat,
                       input logic [4:0] rd,
                       input logic [31:0] pc4);
    ValidM = v; RegWriteM = rw; ResultSrcM = src;
    Funct3M = f3; ALUResultM = alu; ReadDataM = rdat;
    RdM = rd; PCPlus4M = pc4;
  endtask

  task automatic test_reset();
    reset = 1'b0; StallW = 1'($urandom); FlushW = 1'($urandom);
    drive(1'b1, 1'b1, 2'($urandom), 3'($urandom), $urandom,
          $urandom, 5'($urandom), $urandom);
    cyc();
    cyc();
    checks += 6;
    if (RegWriteW !== 1'b0) begin failures++;
      $display("FAIL reset_regwrite got=%b exp=0", RegWriteW); end
    if (RdW !== 5'd0) begin failures++;
      $display("FAIL reset_rd got=%0d exp=0", RdW); end
    if (ResultW !== 32'h0) begin failures++;
      $display("FAIL reset_result got=%h exp=0", ResultW); end
    if (ValidW !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", ValidW); end
    if (InstRetW !== 64'd0) begin failures++;
      $display("FAIL reset_instret got=%0d exp=0", InstRetW); end
    if (s_InstRetW !== 4'd0) begin failures++;
      $display("FAIL reset_instret_s got=%0d exp=0", s_InstRetW); end
    reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_lb();
    logic [31:0] e [4];
    e[0] = 32'h00000001; e[1] = 32'h0000007F;
    e[2] = 32'hFFFFFFFF; e[3] = 32'hFFFFFF80;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h1000 + i,
            32'h80FF7F01, 5'd5, 32'h0);
      cyc();
      checks++;
      if (ResultW !== e[i]) begin failures++;
        $display("FAIL lb_addr%0d got=%h exp=%h", i, ResultW, e[i]); end
    end
    drive(1'b1, 1'b1, 2'b01, 3'b100, 32'h1003,
          32'h80FF7F01, 5'd5, 32'h0);
    cyc();
    checks += 3;
    if (ResultW !== 32'h00000080) begin failures++;
      $display("FAIL lbu_addr3 got=%h exp=00000080", ResultW); end
    if (RegWriteW !== 1'b1 || RdW !== 5'd5) begin failures++;
      $display("FAIL load_wport got=%b/%0d exp=1/5", RegWriteW, RdW); end
    if (ValidW !== 1'b1) begin failures++;
      $display("FAIL load_valid got=%b exp=1", ValidW); end
  endtask

  task automatic test_lh();
    logic [2:0]  f3 [5];
    logic [31:0] ad [5];
    logic [31:0] e  [5];
    f3[0] = 3'b001; ad[0] = 32'h2002; e[0] = 32'hFFFF80FF;
    f3[1] = 3'b101; ad[1] = 32'h2002; e[1] = 32'h000080FF;
    f3[2] = 3'b001; ad[2] = 32'h2001; e[2] = 32'h00007F01;
    f3[3] = 3'b010; ad[3] = 32'h2000; e[3] = 32'h80FF7F01;
    f3[4] = 3'b101; ad[4] = 32'h2003; e[4] = 32'h000080FF;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b01, f3[i], ad[i],
            32'h80FF7F01, 5'd7, 32'h0);
      cyc();
      checks++;
      if (ResultW !== e[i]) begin failures++;
        $display("FAIL lh_vec%0d got=%h exp=%h", i, ResultW, e[i]); end
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 1'b1, 2'b10, 3'b000, 32'hDEAD0000,
          32'h0, 5'd1, 32'h104);
    cyc();
    checks += 3;
    if (RegWriteW !== 1'b1) begin failures++;
      $display("FAIL jal_regwrite got=%b exp=1", RegWriteW); end
    if (RdW !== 5'd1) begin failures++;
      $display("FAIL jal_rd got=%0d exp=1", RdW); end
    if (ResultW !== 32'h104) begin failures++;
      $display("FAIL jal_result got=%h exp=00000104", ResultW); end
    RdM = 5'd0;
    cyc();
    checks += 2;
    if (RegWriteW !== 1'b0) begin failures++;
      $display("FAIL jal_x0_regwrite got=%b exp=0", RegWriteW); end
    if (RdW !== 5'd0) begin failures++;
      $display("FAIL jal_x0_rd got=%0d exp=0", RdW); end
    drive(1'b1, 1'b1, 2'b11, 3'b000, 32'h0000ABCD,
          32'h5555, 5'd3, 32'h200);
    cyc();
    checks++;
    if (ResultW !== 32'h0000ABCD) begin failures++;
      $display("FAIL src11_result got=%h exp=0000abcd", ResultW); end
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h77, 32'h0, 5'd3, 32'h0);
    cyc();
    checks++;
    if (RegWriteW !== 1'b0) begin failures++;
      $display("FAIL norw_regwrite got=%b exp=0", RegWriteW); end
  endtask

  task automatic test_stall();
    logic [63:0] r0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd5, 32'h0, 5'd9, 32'h0);
    cyc();
    r0 = InstRetW;
    StallW = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd9, 32'h0, 5'd4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks += 3;
      if (ResultW !== 32'd5) begin failures++;
        $display("FAIL stall_result%0d got=%h exp=5", i, ResultW); end
      if (RegWriteW !== 1'b1 || RdW !== 5'd9) begin failures++;
        $display("FAIL stall_wport%0d got=%b/%0d exp=1/9", i, RegWriteW, RdW); end
      if (InstRetW !== r0) begin failures++;
        $display("FAIL stall_instret%0d got=%0d exp=%0d", i, InstRetW, r0); end
    end
    StallW = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'h0, 5'd0, 32'h0);
    cyc();
    checks += 2;
    if (InstRetW !== r0 + 64'd1) begin failures++;
      $display("FAIL stall_release got=%0d exp=%0d", InstRetW, r0 + 64'd1); end
    if (InstRetW !== ret) begin failures++;
      $display("FAIL stall_model got=%0d exp=%0d", InstRetW, ret); end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd11, 32'h0, 5'd6, 32'h0);
    cyc();
    FlushW = 1'b1; StallW = 1'b1;
    cyc();
    checks += 3;
    if (ValidW !== 1'b0) begin failures++;
      $display("FAIL flush_valid got=%b exp=0", ValidW); end
    if (RegWriteW !== 1'b0) begin failures++;
      $display("FAIL flush_regwrite got=%b exp=0", RegWriteW); end
    if (InstRetW !== ret) begin failures++;
      $display("FAIL flush_instret got=%0d exp=%0d", InstRetW, ret); end
    FlushW = 1'b1; StallW = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd12, 32'h0, 5'd6, 32'h0);
    cyc();
    FlushW = 1'b0;
    cyc();
    cyc();
    checks++;
    if (InstRetW !== ret) begin failures++;
      $display("FAIL flush_count got=%0d exp=%0d", InstRetW, ret); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd3, 32'h0, 5'd2, 32'h0);
    cyc();
    reset = 1'b0; StallW = 1'b1; FlushW = 1'b1;
    cyc();
    checks += 3;
    if (ValidW !== 1'b0 || RegWriteW !== 1'b0) begin failures++;
      $display("FAIL rstmid_wport got=%b/%b exp=0/0", ValidW, RegWriteW); end
    if (ResultW !== 32'h0) begin failures++;
      $display("FAIL rstmid_result got=%h exp=0", ResultW); end
    if (InstRetW !== 64'd0) begin failures++;
      $display("FAIL rstmid_instret got=%0d exp=0", InstRetW); end
    reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_counter();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 32'(i), 32'h0, 5'd8, 32'h0);
      cyc();
    end
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    cyc();
    checks++;
    if (InstRetW !== 64'd10) begin failures++;
      $display("FAIL cnt_b2b10 got=%0d exp=10", InstRetW); end
    for (int i = 0; i < 3; i++) cyc();
    checks += 2;
    if (InstRetW !== 64'd10) begin failures++;
      $display("FAIL cnt_bubbles got=%0d exp=10", InstRetW); end
    if (s_InstRetW !== 4'd10) begin failures++;
      $display("FAIL cnt_s_10 got=%0d exp=10", s_InstRetW); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 32'(i), 32'h0, 5'd8, 32'h0);
      cyc();
    end
    checks++;
    if (s_InstRetW !== 4'd15) begin failures++;
      $display("FAIL cnt_s_max got=%0d exp=15", s_InstRetW); end
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    cyc();
    checks += 3;
    if (s_InstRetW !== 4'd0) begin failures++;
      $display("FAIL cnt_s_wrap got=%0d exp=0", s_InstRetW); end
    if (InstRetW !== 64'd16) begin failures++;
      $display("FAIL cnt_16 got=%0d exp=16", InstRetW); end
    if (InstRetW !== ret) begin failures++;
      $display("FAIL cnt_model got=%0d exp=%0d", InstRetW, ret); end
  endtask

  initial begin
    checks = 0; failures = 0;
    mv = 1'b0; ret = '0;
    reset = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    test_reset();
    test_lb();
    test_lh();
    test_jal();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
